// File: rtl/ram_req_adapter.sv
// Valid/ready front end for one port of a synchronous RAM (registered address, one-cycle q).
// Read data is captured the cycle after issue into a 2-entry in-order response queue.
module ram_req_adapter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q
);

    logic              inflight_p1;
    logic [1:0]        count;
    logic              head;
    logic              tail;
    logic [DATA_W-1:0] fifo_mem [2];

    logic              req_fire;
    logic              pop;
    logic              push;
    logic [2:0]        credit;

    assign rsp_valid = (count != 2'd0);
    assign rsp_rdata = fifo_mem[head];
    assign pop       = rsp_valid && rsp_ready;
    assign push      = inflight_p1;

    // A slot is owed to every buffered entry and to the read whose data arrives this cycle;
    // a pop in this cycle frees one, so a full queue can still accept while draining.
    assign credit    = {1'b0, count} + {2'b00, inflight_p1} - {2'b00, pop};
    assign req_ready = !reset && (credit < 3'd2);
    assign req_fire  = req_valid && req_ready;

    assign ram_address = req_addr;
    assign ram_data    = req_wdata;
    assign ram_wren    = req_fire && req_write;

    // Stage p1: RAM q is valid the cycle after issue; capture it into the queue tail.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_p1 <= 1'b0;
            count       <= 2'd0;
            head        <= 1'b0;
            tail        <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            inflight_p1 <= req_fire && !req_write;
            if (push) begin
                fifo_mem[tail] <= ram_q;
                tail           <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ram_req_adapter.sv
// Bench for ram_req_adapter: RAM model, directed scenarios and randomized traffic
// checked every cycle against a queue-based reference of outstanding reads.
module tb_ram_req_adapter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] ram_q;

    ram_req_adapter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .ram_address(ram_address),
        .ram_wren   (ram_wren),
        .ram_data   (ram_data),
        .ram_q      (ram_q)
    );

    always #5 clock = ~clock;

    // RAM: registered address, unregistered q
    logic [DATA_W-1:0] ram [4096];
    logic [ADDR_W-1:0] ram_aq;
    always @(posedge clock) begin
        if (ram_wren) ram[ram_address] <= ram_data;
        ram_aq <= ram_address;
    end
    assign ram_q = ram[ram_aq];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: memory contents plus the list of accepted reads awaiting return
    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] d;
    } exp_t;
    exp_t              q[$];
    logic [DATA_W-1:0] model_mem [4096];
    int                cyc = 0;
    int                dut_out = 0;
    bit                cmp_en = 0;

    always @(negedge clock) begin
        if (cmp_en) begin
            bit exp_rv, exp_pop, exp_rdy;
            cyc++;
            exp_rv  = (q.size() > 0) && (q[0].cyc <= cyc - 2);
            exp_pop = exp_rv && rsp_ready;
            exp_rdy = !reset && ((q.size() - int'(exp_pop)) < 2);
            chk("rsp_valid", rsp_valid, exp_rv);
            chk("req_ready", req_ready, exp_rdy);
            chk("ram_wren", ram_wren, req_valid && req_write && exp_rdy);
            chk("ram_address", ram_address, req_addr);
            if (ram_wren) chk("ram_data", ram_data, req_wdata);
            if (exp_rv) chk("rsp_rdata", rsp_rdata, q[0].d);

            if (reset) dut_out = 0;
            else dut_out += int'(req_valid && req_ready && !req_write) - int'(rsp_valid && rsp_ready);
            chk("no_overflow", dut_out <= 2, 1);

            if (reset) begin
                q.delete();
            end else begin
                if (exp_pop) void'(q.pop_front());
                if (req_valid && exp_rdy) begin
                    if (req_write) model_mem[req_addr] = req_wdata;
                    else q.push_back('{cyc: cyc, d: model_mem[req_addr]});
                end
            end
        end
    end

    // rsp_ready driver: 0 = held by stimulus, 1 = random, 2 = toggle
    int rsp_mode = 0;
    always @(posedge clock) begin
        #1;
        if (rsp_mode == 1) rsp_ready = 1'($urandom_range(0, 1));
        else if (rsp_mode == 2) rsp_ready = ~rsp_ready;
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic do_req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n = 0;
        drive(1'b1, w, a, d);
        @(negedge clock);
        while (!req_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (n >= 40) chk("req_accept_timeout", 0, 1);
        next_cycle();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]       = '0;
            model_mem[i] = '0;
        end
        reset     = 1'b1;
        rsp_ready = 1'b0;
        drive(1'b1, 1'b1, 12'h010, 32'hDEADBEEF);

        // Reset state, with a write request presented during reset
        next_cycle();
        cmp_en = 1;
        @(negedge clock);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_ram_wren", ram_wren, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        next_cycle();

        // Write then read the same address
        reset = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b1, 1'b1, 12'h010, 32'h12345678);
        @(negedge clock);
        chk("wr_ram_wren", ram_wren, 1);
        next_cycle();
        drive(1'b1, 1'b0, 12'h010, 32'h0);
        @(negedge clock);
        chk("rd_ram_wren", ram_wren, 0);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clock);
        chk("raw_not_yet_valid", rsp_valid, 0);
        next_cycle();
        @(negedge clock);
        chk("raw_rsp_valid", rsp_valid, 1);
        chk("raw_rsp_rdata", rsp_rdata, 32'h12345678);
        next_cycle();

        // Streaming reads after preload
        for (int i = 0; i < 8; i++) do_req(1'b1, 12'(i), 32'(i * 3));
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(1'b1, 1'b0, 12'(k), 32'h0);
            else req_valid = 1'b0;
            @(negedge clock);
            if (k < 8) chk("stream_ready", req_ready, 1);
            if (k >= 2) begin
                chk("stream_rsp_valid", rsp_valid, 1);
                chk("stream_rsp_rdata", rsp_rdata, 32'((k - 2) * 3));
            end
            next_cycle();
        end

        // Backpressure: two reads accepted, then stall
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 12'd0, 32'h0);
        @(negedge clock);
        chk("bp_ready0", req_ready, 1);
        next_cycle();
        drive(1'b1, 1'b0, 12'd1, 32'h0);
        @(negedge clock);
        chk("bp_ready1", req_ready, 1);
        next_cycle();
        drive(1'b1, 1'b0, 12'd2, 32'h0);
        @(negedge clock);
        chk("bp_ready2", req_ready, 0);
        next_cycle();
        @(negedge clock);
        chk("bp_ready3", req_ready, 0);
        chk("bp_head_data", rsp_rdata, 32'd0);
        next_cycle();
        drive(1'b1, 1'b1, 12'h3FF, 32'hCAFEF00D);
        @(negedge clock);
        chk("stall_wr_ready", req_ready, 0);
        chk("stall_wr_wren", ram_wren, 0);
        next_cycle();
        rsp_ready = 1'b1;
        do_req(1'b0, 12'd2, 32'h0);
        do_req(1'b0, 12'd3, 32'h0);
        repeat (4) next_cycle();

        // Toggling rsp_ready under continuous reads
        rsp_mode = 2;
        for (int i = 0; i < 20; i++) do_req(1'b0, 12'(i % 8), 32'h0);
        rsp_mode = 0;
        rsp_ready = 1'b1;
        repeat (4) next_cycle();

        // Reset mid-flight
        drive(1'b1, 1'b0, 12'd5, 32'h0);
        @(negedge clock);
        chk("mid_rd_ready", req_ready, 1);
        next_cycle();
        req_valid = 1'b0;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_rsp_valid0", rsp_valid, 0);
        next_cycle();
        @(negedge clock);
        chk("post_rst_rsp_valid1", rsp_valid, 0);
        next_cycle();
        drive(1'b1, 1'b0, 12'd5, 32'h0);
        next_cycle();
        req_valid = 1'b0;
        next_cycle();
        @(negedge clock);
        chk("fresh_rsp_valid", rsp_valid, 1);
        chk("fresh_rsp_rdata", rsp_rdata, 32'd15);
        next_cycle();

        // Randomized traffic over a small address window with occasional reset
        rsp_mode = 1;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  12'($urandom_range(0, 15)), $urandom);
            reset = ($urandom_range(0, 60) == 0);
            next_cycle();
        end
        reset = 1'b0;
        req_valid = 1'b0;
        rsp_mode = 0;
        rsp_ready = 1'b1;
        repeat (5) next_cycle();
        @(negedge clock);
        chk("drained_rsp_valid", rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
